// File: rtl/hps_cmd_bridge.sv
// hps_cmd_bridge: decodes HPS PIO command words under a REQ/ACK handshake, issues them to the
// coprocessor over valid/ready, and reports status/result and saturating statistics back to the HPS.
module hps_cmd_bridge #(
    parameter int OPCODE_W = 4,
    parameter int ADDR_W = 19,
    parameter int DATA_W = 8,
    parameter int RESULT_W = 16,
    parameter int NUM_OPS = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter logic [15:0] CNT_MAX = 16'hFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         pio_data_out,
    output logic [31:0]         pio_data_in,
    output logic [31:0]         pio_control,
    output logic                cmd_valid,
    input  logic                cmd_ready,
    output logic [OPCODE_W-1:0] cmd_opcode,
    output logic [ADDR_W-1:0]   cmd_addr,
    output logic [DATA_W-1:0]   cmd_data,
    input  logic                done_valid,
    input  logic                done_error,
    input  logic [RESULT_W-1:0] done_result
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [OPCODE_W:0] OPS_LIM = (OPCODE_W + 1)'(NUM_OPS);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_ACK} state_t;

    state_t state, state_n;
    logic req_q, err_q, tmo_q, err_n;
    logic [15:0] res_q, done_cnt, err_cnt;
    logic [TW-1:0] timer;
    logic [OPCODE_W-1:0] op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    wire req = pio_data_out[31];
    wire rise = req & ~req_q;
    wire [OPCODE_W-1:0] op_w = pio_data_out[27 +: OPCODE_W];
    wire legal = {1'b0, op_w} < OPS_LIM;
    wire tmo_hit = timer == TW'(TIMEOUT_CYCLES - 1);
    wire enter_ack = (state_n == S_ACK) && (state != S_ACK);

    assign cmd_valid = state == S_ISSUE;
    assign cmd_opcode = op_q;
    assign cmd_addr = addr_q;
    assign cmd_data = data_q;

    always_comb begin
        state_n = state;
        err_n = 1'b1;
        case (state)
            S_IDLE: begin
                if (rise) begin
                    state_n = legal ? S_ISSUE : S_ACK;
                    err_n = !legal;
                end
            end
            S_ISSUE: state_n = cmd_ready ? S_WAIT : S_ISSUE;
            S_WAIT: begin
                // a completion arriving on the timeout cycle takes priority
                if (done_valid || tmo_hit) begin
                    state_n = S_ACK;
                    err_n = done_valid ? done_error : 1'b1;
                end
            end
            S_ACK: state_n = req ? S_ACK : S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            req_q <= 1'b0;
            op_q <= '0;
            addr_q <= '0;
            data_q <= '0;
            err_q <= 1'b0;
            tmo_q <= 1'b0;
            res_q <= '0;
            timer <= '0;
            done_cnt <= '0;
            err_cnt <= '0;
            pio_data_in <= '0;
            pio_control <= '0;
        end else begin
            state <= state_n;
            req_q <= req;
            pio_data_in <= {state == S_ACK, state == S_ISSUE || state == S_WAIT, err_q, tmo_q, 12'd0, res_q};
            pio_control <= {err_cnt, done_cnt};
            if (state == S_IDLE && rise) begin
                op_q <= op_w;
                addr_q <= pio_data_out[8 +: ADDR_W];
                data_q <= pio_data_out[0 +: DATA_W];
                err_q <= !legal;
                tmo_q <= 1'b0;
                res_q <= '0;
            end
            if (state == S_ISSUE && cmd_ready)
                timer <= '0;
            if (state == S_WAIT) begin
                if (done_valid) begin
                    res_q <= 16'(done_result);
                    err_q <= done_error;
                end else if (tmo_hit) begin
                    err_q <= 1'b1;
                    tmo_q <= 1'b1;
                    res_q <= '0;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
            if (enter_ack) begin
                done_cnt <= (done_cnt == CNT_MAX) ? done_cnt : done_cnt + 16'd1;
                if (err_n)
                    err_cnt <= (err_cnt == CNT_MAX) ? err_cnt : err_cnt + 16'd1;
            end
        end
    end
endmodule
